// File: rtl/fifo_16to8_unpack.sv
// Drains 16-bit words from a normal-mode FIFO read port and emits them as two bytes on a valid/ready stream.
// Byte order is low byte first unless FIFO_UNPACK_MSB_FIRST_EN is defined, in which case the high byte goes first.
module fifo_16to8_unpack #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rd_empty,
  input  logic [15:0]      rd_data,
  output logic             rd_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BYTE0 = 2'd2,
    ST_BYTE1 = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic [7:0]       r_hi;
  logic [CNT_W-1:0] r_byte_cnt;

  logic             w_rd_req;
  logic             w_load;
  logic             w_advance;
  logic             w_drain;
  logic             w_fire;

  function automatic logic [7:0] f_first_byte(input logic [15:0] word);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return word[15:8];
`else
    return word[7:0];
`endif
  endfunction

  function automatic logic [7:0] f_second_byte(input logic [15:0] word);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return word[7:0];
`else
    return word[15:8];
`endif
  endfunction

  assign w_fire = r_out_valid & out_ready;

  // Next-state and pop decision; a pop is only ever issued from IDLE or a completing BYTE1.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rd_empty) begin
          w_rd_req    = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_load      = 1'b1;
        w_state_nxt = ST_BYTE0;
      end
      ST_BYTE0: begin
        if (w_fire) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_BYTE1;
        end else begin
          w_state_nxt = ST_BYTE0;
        end
      end
      ST_BYTE1: begin
        if (w_fire) begin
          w_drain = 1'b1;
          if (!rd_empty) begin
            w_rd_req    = 1'b1;
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_BYTE1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset must also mask the pop so a word is never lost to a discarded transition.
  assign rd_req = w_rd_req & ~sys_rst;

  // State register and busy flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Output byte register and buffered second byte.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_hi        <= 8'h00;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= f_first_byte(rd_data);
      r_hi        <= f_second_byte(rd_data);
    end else if (w_advance) begin
      r_out_data  <= r_hi;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Transferred-byte counter, free-running modulo 2^CNT_W.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_byte_cnt <= {CNT_W{1'b0}};
    end else if (w_fire) begin
      r_byte_cnt <= r_byte_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_byte_cnt <= r_byte_cnt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_fifo_16to8_unpack.sv
// Directed, table-driven bench for fifo_16to8_unpack with a behavioural normal-mode FIFO on the read side.
// Byte-order expectations follow FIFO_UNPACK_MSB_FIRST_EN when the bench is built with it.
module tb_fifo_16to8_unpack;
  localparam int CNT_W = 3;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             rd_empty;
  logic [15:0]      rd_data = 16'h0000;
  logic             rd_req;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             busy;
  logic [CNT_W-1:0] byte_cnt;

  logic [15:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_vec = 0;
  int n_err = 0;

  fifo_16to8_unpack #(.CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_req(rd_req), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  assign rd_empty = (wr_ptr == rd_ptr);

  // Normal-mode FIFO: data appears the cycle after the pop.
  always @(posedge sys_clk) begin
    if (rd_req && rd_empty) begin
      $display("FAIL over_read: rd_req=1 while rd_empty=1 (required rd_req=0) at %0t", $time);
      n_err <= n_err + 1;
    end else if (rd_req) begin
      rd_data <= mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  function automatic logic [7:0] fb(input logic [15:0] w);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  function automatic logic [7:0] sb(input logic [15:0] w);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  typedef struct {
    logic        rst;
    logic        push;
    logic [15:0] word;
    logic        rdy;
    logic        e_req;
    logic        e_vld;
    logic [7:0]  e_data;
    logic        e_busy;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic push, input logic [15:0] word, input logic rdy,
                              input logic e_req, input logic e_vld, input logic [7:0] e_data,
                              input logic e_busy, input int e_cnt);
    vec_t v;
    v.rst = rst; v.push = push; v.word = word; v.rdy = rdy;
    v.e_req = e_req; v.e_vld = e_vld; v.e_data = e_data; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
      n_err = n_err + 1;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  logic [CNT_W-1:0] ec;
  logic [7:0] got [0:15];
  logic [7:0] exp_b [0:5];
  int nb, nv, nreq;
  logic [15:0] tw [0:2];

  initial begin
    sys_rst = 1'b1;
    out_ready = 1'b0;

    // Single word
    vecs.push_back(mk(0,1,16'h2211,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h2211),1,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,sb(16'h2211),1,1));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,0,2));
    // Burst of four words, valid pattern 1,1,0
    vecs.push_back(mk(0,1,16'h0201,1, 1,0,8'h00,0,2));
    vecs.push_back(mk(0,1,16'h0403,1, 0,0,8'h00,1,2));
    vecs.push_back(mk(0,1,16'h0605,1, 0,1,fb(16'h0201),1,2));
    vecs.push_back(mk(0,1,16'h0807,1, 1,1,sb(16'h0201),1,3));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,4));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h0403),1,4));
    vecs.push_back(mk(0,0,16'h0000,1, 1,1,sb(16'h0403),1,5));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,6));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h0605),1,6));
    vecs.push_back(mk(0,0,16'h0000,1, 1,1,sb(16'h0605),1,7));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,8));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h0807),1,8));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,sb(16'h0807),1,9));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,0,10));
    // Back-pressure in BYTE0 for 5 cycles, then a stall in BYTE1 with the FIFO non-empty
    vecs.push_back(mk(0,1,16'h3CA5,0, 1,0,8'h00,0,10));
    vecs.push_back(mk(0,0,16'h0000,0, 0,0,8'h00,1,10));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0,0,16'h0000,0, 0,1,fb(16'h3CA5),1,10));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h3CA5),1,10));
    vecs.push_back(mk(0,1,16'h1234,0, 0,1,sb(16'h3CA5),1,11));
    vecs.push_back(mk(0,0,16'h0000,1, 1,1,sb(16'h3CA5),1,11));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,12));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h1234),1,12));
    // FIFO empty in BYTE1: drain and park in IDLE, restart when empty falls
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,sb(16'h1234),1,13));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,0,14));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,0,14));
    vecs.push_back(mk(0,1,16'h5678,1, 1,0,8'h00,0,14));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,14));
    vecs.push_back(mk(0,0,16'h0000,0, 0,1,fb(16'h5678),1,14));
    // Reset in BYTE0: second byte of 5678 must never appear
    vecs.push_back(mk(1,1,16'h9ABC,1, 0,1,fb(16'h5678),1,14));
    vecs.push_back(mk(1,0,16'h0000,1, 0,0,8'h00,0,0));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,1,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,fb(16'h9ABC),1,0));
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,sb(16'h9ABC),1,1));
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,8'h00,0,2));

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    n_vec = n_vec + 1;
    chk("rst_valid", -1, {15'd0, out_valid}, 16'd0);
    chk("rst_data",  -1, {8'd0, out_data},   16'd0);
    chk("rst_busy",  -1, {15'd0, busy},      16'd0);
    chk("rst_cnt",   -1, {13'd0, byte_cnt},  16'd0);
    chk("rst_req",   -1, {15'd0, rd_req},    16'd0);

    foreach (vecs[i]) begin
      @(negedge sys_clk);
      sys_rst = vecs[i].rst;
      out_ready = vecs[i].rdy;
      if (vecs[i].push) push_word(vecs[i].word);
      #1;
      n_vec = n_vec + 1;
      ec = vecs[i].e_cnt[CNT_W-1:0];
      chk("rd_req",    i, {15'd0, rd_req},    {15'd0, vecs[i].e_req});
      chk("out_valid", i, {15'd0, out_valid}, {15'd0, vecs[i].e_vld});
      chk("busy",      i, {15'd0, busy},      {15'd0, vecs[i].e_busy});
      chk("byte_cnt",  i, {13'd0, byte_cnt},  {13'd0, ec});
      if (vecs[i].e_vld) chk("out_data", i, {8'd0, out_data}, {8'd0, vecs[i].e_data});
    end

    // Sustained throughput: three queued words over ten cycles give six bytes and three pops
    tw[0] = 16'hA1B2; tw[1] = 16'hC3D4; tw[2] = 16'hE5F6;
    for (int k = 0; k < 3; k++) begin
      exp_b[2*k]   = fb(tw[k]);
      exp_b[2*k+1] = sb(tw[k]);
    end
    nb = 0; nv = 0; nreq = 0;
    @(negedge sys_clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_word(tw[k]);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (nb < 16) got[nb] = out_data;
        nb = nb + 1;
        nv = nv + 1;
      end
      if (rd_req) nreq = nreq + 1;
      @(negedge sys_clk);
    end
    n_vec = n_vec + 1;
    chk("tput_valid_cycles", -2, nv[15:0], 16'd6);
    chk("tput_rd_req", -2, nreq[15:0], 16'd3);
    for (int k = 0; k < 6; k++) chk("tput_byte", k, {8'd0, got[k]}, {8'd0, exp_b[k]});

    // Bounded wait for the FSM to go idle; counter has wrapped 2+6 -> 0
    begin
      int t = 0;
      while (busy && t < 10) begin
        @(negedge sys_clk);
        #1;
        t = t + 1;
      end
      n_vec = n_vec + 1;
      if (busy) begin
        $display("FAIL idle_timeout: busy=%0d after %0d cycles, expected 0", busy, t);
        n_err = n_err + 1;
      end else begin
        chk("wrap_cnt", -3, {13'd0, byte_cnt}, 16'd0);
        chk("idle_valid", -3, {15'd0, out_valid}, 16'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
